// File: rtl/ingress_frame_buffer_pkg.sv
// Shared definitions for the ingress frame buffer and the header decoder that reads it.
package ingress_frame_buffer_pkg;

   localparam int ICE_ADDR_W    = 9;
   localparam int FRAME_EOF_BIT = 8;
   localparam int ICE_DATA_W    = FRAME_EOF_BIT + 1;

   typedef enum logic {
      W_ACCEPT = 1'b0,
      W_DROP   = 1'b1
   } wr_state_e;

endpackage

// File: rtl/ingress_frame_buffer_frame_ram.sv
// Simple dual-port frame store: one synchronous write port, one registered read port.
// The read sees the old word when it hits the address being written that cycle.
module ingress_frame_buffer_frame_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 9
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ingress_frame_buffer.sv
// Circular frame store: bytes are written speculatively and only published to the
// decoder once the frame's last byte is in; frames that do not fit are dropped whole.
module ingress_frame_buffer
   import ingress_frame_buffer_pkg::*;
#(
   parameter int ADDR_W = ICE_ADDR_W,
   parameter int DATA_W = ICE_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [7:0]        wr_data,
   input  logic              wr_last,
   output logic              overflow,
   output logic [ADDR_W-1:0] free_space,
   output logic              frame_valid,
   output logic [ADDR_W-1:0] frame_count,
   output logic [ADDR_W-1:0] tail,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   input  logic              latch_tail
);

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] commit_ptr_q, commit_ptr_d;
   logic [ADDR_W-1:0] tail_q, tail_d;
   logic [ADDR_W-1:0] frame_count_q, frame_count_d;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              overflow_q, overflow_d;
   logic              rd_primed_q;
   logic              ram_we;
   logic              commit_frame;
   logic              release_frame;
   logic [DATA_W-1:0] ram_rd_data;
   logic [ADDR_W-1:0] rd_offset;
   logic [ADDR_W-1:0] commit_offset;

   // One slot stays empty so that tail == wr_ptr always means "empty".
   assign free_space = tail_q - wr_ptr_q - ADDR_W'(1);

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      commit_ptr_d  = commit_ptr_q;
      tail_d        = tail_q;
      frame_count_d = frame_count_q;
      overflow_d    = 1'b0;
      ram_we        = 1'b0;
      commit_frame  = 1'b0;
      release_frame = latch_tail && (frame_count_q != '0);

      if (release_frame) begin
         tail_d = rd_addr;
      end

      unique case (state_q)
         W_ACCEPT: begin
            if (wr_valid) begin
               if (free_space != '0) begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                  if (wr_last) begin
                     commit_ptr_d = wr_ptr_q + ADDR_W'(1);
                     commit_frame = 1'b1;
                  end
               end else begin
                  // Out of room: discard the partial frame and swallow the rest of it.
                  wr_ptr_d   = commit_ptr_q;
                  overflow_d = 1'b1;
                  if (!wr_last) begin
                     state_d = W_DROP;
                  end
               end
            end
         end
         W_DROP: begin
            if (wr_valid && wr_last) begin
               state_d = W_ACCEPT;
            end
         end
         default: state_d = W_ACCEPT;
      endcase

      unique case ({commit_frame, release_frame})
         2'b10:   frame_count_d = frame_count_q + ADDR_W'(1);
         2'b01:   frame_count_d = frame_count_q - ADDR_W'(1);
         default: frame_count_d = frame_count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= W_ACCEPT;
         wr_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         tail_q        <= '0;
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
         rd_addr_q     <= '0;
         rd_primed_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         commit_ptr_q  <= commit_ptr_d;
         tail_q        <= tail_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
         rd_addr_q     <= rd_addr;
         rd_primed_q   <= 1'b1;
      end
   end

   ingress_frame_buffer_frame_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_frame_ram (
      .clk       (clk),
      .wr_en_i   (ram_we),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i ({wr_last, wr_data}),
      .rd_addr_i (rd_addr),
      .rd_data_o (ram_rd_data)
   );

   // The block RAM output has no reset; mask it until the first read after reset.
   assign rd_data = rd_primed_q ? ram_rd_data : '0;

   assign rd_offset     = rd_addr_q - tail_q;
   assign commit_offset = commit_ptr_q - tail_q;
   assign rd_data_valid = (rd_addr_q == rd_addr) && (rd_offset < commit_offset);

   assign overflow    = overflow_q;
   assign frame_valid = (frame_count_q != '0);
   assign frame_count = frame_count_q;
   assign tail        = tail_q;

endmodule

// File: tb/tb_ingress_frame_buffer.sv
// Scoreboard bench: a frame-level reference model predicts every output each cycle,
// a separate monitor pops the predictions at the falling edge and compares.
module tb_ingress_frame_buffer;

   localparam int DEPTH = 512;
   localparam int M     = DEPTH - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_last;
   logic       overflow;
   logic [8:0] free_space;
   logic       frame_valid;
   logic [8:0] frame_count;
   logic [8:0] tail;
   logic [8:0] rd_addr;
   logic [8:0] rd_data;
   logic       rd_data_valid;
   logic       latch_tail;

   always #5 clk = ~clk;

   ingress_frame_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_last       (wr_last),
      .overflow      (overflow),
      .free_space    (free_space),
      .frame_valid   (frame_valid),
      .frame_count   (frame_count),
      .tail          (tail),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .latch_tail    (latch_tail)
   );

   typedef struct {
      int free;
      int count;
      bit fvalid;
      int tail;
      bit ovf;
      bit rdv;
      int rdd;
      bit chk_rdd;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: committed frames as a queue of end addresses, plus the partial frame.
   int m_tail, m_commit, m_plen, m_rdq, m_rdd;
   bit m_drop, m_ovf;
   int m_ends[$];
   int m_mem[DEPTH];
   int cur_a = 0;

   function automatic int m_free();
      return (m_tail - m_commit - m_plen - 1) & M;
   endfunction

   function automatic bit m_in_region(int a);
      return ((a - m_tail) & M) < ((m_commit - m_tail) & M);
   endfunction

   task automatic model_reset();
      m_tail = 0; m_commit = 0; m_plen = 0; m_rdq = 0; m_rdd = 0;
      m_drop = 0; m_ovf = 0;
      m_ends.delete();
   endtask

   task automatic model_edge();
      int f   = m_free();
      bit rel = latch_tail && (m_ends.size() > 0);
      int a   = int'(rd_addr);
      m_rdd = m_mem[a];
      m_rdq = a;
      m_ovf = 0;
      if (wr_valid) begin
         if (m_drop) begin
            if (wr_last) m_drop = 0;
         end else if (f > 0) begin
            m_mem[(m_commit + m_plen) & M] = int'({wr_last, wr_data});
            m_plen++;
            if (wr_last) begin
               $display("[%0t] frame committed start=%0d len=%0d", $time, m_commit, m_plen);
               m_commit = (m_commit + m_plen) & M;
               m_ends.push_back(m_commit);
               m_plen = 0;
            end
         end else begin
            $display("[%0t] frame dropped, no space (free=0)", $time);
            m_ovf  = 1;
            m_plen = 0;
            m_drop = !wr_last;
         end
      end
      if (rel) begin
         $display("[%0t] frame released, tail -> %0d", $time, a);
         m_tail = a;
         void'(m_ends.pop_front());
      end
   endtask

   task automatic push_expect();
      exp_t e;
      e.free    = m_free();
      e.count   = m_ends.size();
      e.fvalid  = (m_ends.size() != 0);
      e.tail    = m_tail;
      e.ovf     = m_ovf;
      e.rdv     = !rst && (m_rdq == int'(rd_addr)) && m_in_region(m_rdq);
      e.rdd     = rst ? 0 : m_rdd;
      e.chk_rdd = rst || e.rdv;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus: drive, predict, advance the model over the edge.
   task automatic step(input bit v, input int d, input bit l, input int a, input bit lt, input bit r);
      logic [31:0] dv;
      logic [31:0] av;
      dv = d;
      av = a;
      rst        = r;
      wr_valid   = v;
      wr_data    = dv[7:0];
      wr_last    = l;
      rd_addr    = av[8:0];
      latch_tail = lt;
      cur_a      = a & M;
      if (r) model_reset();
      push_expect();
      @(posedge clk);
      if (r) model_reset();
      else   model_edge();
      #1;
   endtask

   task automatic idle(input int a, input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, a, 0, 0);
   endtask

   task automatic send_frame(input int len, input int a);
      for (int i = 0; i < len; i++) step(1, $urandom_range(0, 255), (i == len - 1), a, 0, 0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[%0t] FAIL %s: got %0h expected %0h", $time, name, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("free_space", 32'(free_space), e.free);
            chk("frame_count", 32'(frame_count), e.count);
            chk("frame_valid", 32'(frame_valid), 32'(e.fvalid));
            chk("tail", 32'(tail), e.tail);
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("rd_data_valid", 32'(rd_data_valid), 32'(e.rdv));
            if (e.chk_rdd) chk("rd_data", 32'(rd_data), e.rdd);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel_pct, last_mod, a;
      bit lt;
      rst = 1'b1; wr_valid = 0; wr_data = 0; wr_last = 0; rd_addr = 0; latch_tail = 0;
      model_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

      // Single frame 05, AA, 03(last), then read each word and step past the end.
      step(1, 'h05, 0, 0, 0, 0);
      step(1, 'hAA, 0, 0, 0, 0);
      step(1, 'h03, 1, 0, 0, 0);
      idle(0, 2); idle(1, 2); idle(2, 2); idle(3, 3);
      step(0, 0, 0, 3, 1, 0);
      idle(3, 2);

      // Overflow: a 510-byte frame leaves one slot; the next frame is dropped.
      send_frame(510, 3);
      send_frame(5, 3);
      idle(3, 2);
      step(0, 0, 0, 1, 1, 0);

      // Wrap-around: bring tail and commit to 510, then store 510, 511, 0, 1.
      send_frame(509, 1);
      step(0, 0, 0, 510, 1, 0);
      send_frame(4, 510);
      for (int k = 0; k < 6; k++) idle((510 + k) & M, 2);
      step(0, 0, 0, 2, 1, 0);
      idle(2, 2);

      // Commit of frame 2 in the same cycle as the release of frame 1.
      send_frame(3, 2);
      step(1, 'h11, 0, 2, 0, 0);
      step(1, 'h22, 0, 2, 0, 0);
      step(1, 'h33, 1, 5, 1, 0);
      idle(5, 3); idle(6, 2); idle(7, 2);

      // Reset in the middle of a frame, then a fresh frame lands at address 0.
      step(1, 'h44, 0, 0, 0, 0);
      step(1, 'h55, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      send_frame(4, 0);
      for (int k = 0; k < 5; k++) idle(k, 2);
      step(0, 0, 0, 4, 1, 0);

      // Randomized traffic with varying release rates and frame lengths.
      for (int ph = 0; ph < 4; ph++) begin
         rel_pct  = (ph == 0) ? 8 : (ph == 1) ? 1 : (ph == 2) ? 4 : 15;
         last_mod = (ph == 1) ? 64 : 8;
         for (int c = 0; c < 1500; c++) begin
            lt = ($urandom_range(0, 99) < rel_pct);
            if (lt && m_ends.size() > 0) a = m_ends[0];
            else if ($urandom_range(0, 3) == 0)
               a = (m_tail + $urandom_range(0, ((m_commit - m_tail) & M) + 1)) & M;
            else a = cur_a;
            step($urandom_range(0, 9) < 6, $urandom_range(0, 255),
                 $urandom_range(0, last_mod - 1) == 0, a, lt,
                 $urandom_range(0, 1999) == 0);
         end
      end

      idle(cur_a, 3);
      @(negedge clk);
      #1;
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
